// File: rtl/wregbank4_pkg.sv
// wregbank4_pkg: constants and types shared by the general register bank
// write side (wregbank4) and the read-mux side.
//   DW    register data width
//   AW    register address width
//   NREG  number of registers (2^AW)
//   BEW   byte-enable width (DW/8)
//   state_e  write-side sequencer state {IDLE, CLEAR}
package wregbank4_pkg;

    localparam int DW   = 64;
    localparam int AW   = 2;
    localparam int NREG = 4;
    localparam int BEW  = DW / 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage : wregbank4_pkg

// File: rtl/waddr_dec2_4.sv
// waddr_dec2_4: 2-to-4 write-address decoder for the register bank.
//   addr  in  2  register index of the committing write
//   en    in  1  a write commits this cycle
//   we    out 4  one-hot write enable, all zero when en=0
module waddr_dec2_4 (
    input  logic [1:0] addr,
    input  logic       en,
    output logic [3:0] we
);

    // One-hot decode of the commit address, gated by en.
    always_comb begin
        we = 4'b0000;
        if (en) begin
            case (addr)
                2'd0:    we = 4'b0001;
                2'd1:    we = 4'b0010;
                2'd2:    we = 4'b0100;
                2'd3:    we = 4'b1000;
                default: we = 4'b0000;
            endcase
        end else begin
            we = 4'b0000;
        end
    end

endmodule : waddr_dec2_4

// File: rtl/wregbank4.sv
// wregbank4: write side of the four-entry general register bank.
// Byte-masked writes are accepted over valid/ready, staged for one cycle,
// then merged into R[addr]. A clear command zeroes R0..R3 one per cycle.
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_valid/wr_ready   write request handshake (ready is combinational)
//   wr_addr/data/be     write target, data and byte enables
//   clr_req             single-cycle clear command
//   clr_busy            clear sequence running
//   wr_pend/_addr       staged write awaiting commit and its address
//   R0..R3              committed register contents
module wregbank4
    import wregbank4_pkg::*;
#(
    parameter int DW = wregbank4_pkg::DW,
    parameter int AW = wregbank4_pkg::AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_be,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_pend,
    output logic [AW-1:0]     wr_pend_addr,
    output logic [DW-1:0]     R0,
    output logic [DW-1:0]     R1,
    output logic [DW-1:0]     R2,
    output logic [DW-1:0]     R3
);

    localparam int LBEW = DW / 8;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              pend_q, pend_d;
    logic [AW-1:0]     pend_addr_q, pend_addr_d;
    logic [DW-1:0]     pend_data_q, pend_data_d;
    logic [LBEW-1:0]   pend_be_q, pend_be_d;
    logic [DW-1:0]     regs_q [NREG];
    logic [DW-1:0]     regs_d [NREG];
    logic [NREG-1:0]   we_s;
    logic              accept_s;

    // Ready only depends on the sequencer state and the clear command so a
    // clear always wins over a same-cycle write.
    assign wr_ready = (state_q == IDLE) && !clr_req;
    assign accept_s = wr_valid && wr_ready;

    waddr_dec2_4 u_dec (
        .addr (pend_addr_q),
        .en   (pend_q),
        .we   (we_s)
    );

    // Stage register: holds exactly one accepted write for one cycle; the
    // address is forced to zero when nothing is staged.
    always_comb begin
        pend_d      = 1'b0;
        pend_addr_d = '0;
        pend_data_d = '0;
        pend_be_d   = '0;
        if (accept_s) begin
            pend_d      = 1'b1;
            pend_addr_d = wr_addr;
            pend_data_d = wr_data;
            pend_be_d   = wr_be;
        end else begin
            pend_d      = 1'b0;
            pend_addr_d = '0;
            pend_data_d = '0;
            pend_be_d   = '0;
        end
    end

    // Clear sequencer: IDLE -> CLEAR on clr_req, walk the index R0..R3,
    // then back to IDLE. clr_req is ignored while clearing.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else begin
                    state_d   = IDLE;
                    clr_idx_d = clr_idx_q;
                end
            end
            CLEAR: begin
                if (clr_idx_q == AW'(NREG - 1)) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    state_d   = CLEAR;
                    clr_idx_d = clr_idx_q + AW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    // Register next-state: clear zeroing takes priority, otherwise the
    // decoded commit merges enabled bytes and the rest hold.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            if ((state_q == CLEAR) && (clr_idx_q == AW'(r))) begin
                regs_d[r] = '0;
            end else if (we_s[r]) begin
                for (int b = 0; b < LBEW; b++) begin
                    if (pend_be_q[b]) begin
                        regs_d[r][8*b +: 8] = pend_data_q[8*b +: 8];
                    end else begin
                        regs_d[r][8*b +: 8] = regs_q[r][8*b +: 8];
                    end
                end
            end else begin
                regs_d[r] = regs_q[r];
            end
        end
    end

    // State flops; asynchronous reset aborts any clear in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clr_idx_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_be_q   <= '0;
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_be_q   <= pend_be_d;
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    assign clr_busy     = (state_q == CLEAR);
    assign wr_pend      = pend_q;
    assign wr_pend_addr = pend_addr_q;
    assign R0           = regs_q[0];
    assign R1           = regs_q[1];
    assign R2           = regs_q[2];
    assign R3           = regs_q[3];

endmodule : wregbank4

// File: tb/tb_wregbank4.sv
// tb_wregbank4: scoreboard bench for wregbank4. The driver predicts
// acceptance and the post-commit register value from an array model;
// a monitor pops expectations whenever the DUT shows a staged write.
module tb_wregbank4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        clr_req;
    logic        clr_busy;
    logic        wr_pend;
    logic [1:0]  wr_pend_addr;
    logic [63:0] R0, R1, R2, R3;
    logic [63:0] rr [4];

    typedef struct packed {
        logic [1:0]  a;
        logic [63:0] v;
    } exp_t;

    exp_t        sb_q [$];
    logic [63:0] model [4];
    int          clr_left = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rr[0] = R0;
    assign rr[1] = R1;
    assign rr[2] = R2;
    assign rr[3] = R3;

    wregbank4 #(.DW(64), .AW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_be        (wr_be),
        .clr_req      (clr_req),
        .clr_busy     (clr_busy),
        .wr_pend      (wr_pend),
        .wr_pend_addr (wr_pend_addr),
        .R0           (R0),
        .R1           (R1),
        .R2           (R2),
        .R3           (R3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("%s_R%0d", tag, r), rr[r], model[r]);
        end
    endtask

    // One bus cycle: drive at posedge+1, check ready/busy mid-cycle,
    // update the model and scoreboard for an accepted write.
    task automatic cycle(input bit v, input logic [1:0] a, input logic [63:0] d,
                         input logic [7:0] be, input bit c);
        bit          exp_rdy;
        logic [63:0] mask;
        @(posedge clk);
        #1;
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        clr_req  = c;
        @(negedge clk);
        exp_rdy = (clr_left == 0) && !c;
        chk("wr_ready", {63'd0, wr_ready}, {63'd0, exp_rdy});
        chk("clr_busy", {63'd0, clr_busy}, {63'd0, (clr_left > 0)});
        if (v && exp_rdy) begin
            for (int b = 0; b < 8; b++) begin
                mask[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
            end
            model[a] = (model[a] & ~mask) | (d & mask);
            sb_q.push_back('{a: a, v: model[a]});
        end
        if (clr_left > 0) begin
            clr_left--;
        end else if (c) begin
            clr_left = 4;
            for (int r = 0; r < 4; r++) model[r] = 64'd0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 64'd0, 8'h00, 1'b0);
    endtask

    // Monitor: every staged write must match the oldest expectation, and the
    // target register must hold the expected value one cycle later.
    initial begin
        bit          have = 1'b0;
        logic [1:0]  ca;
        logic [63:0] cv;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 1'b0;
            end else begin
                if (have) begin
                    chk($sformatf("commit_R%0d", ca), rr[ca], cv);
                    have = 1'b0;
                end
                if (wr_pend) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_pend", {63'd0, wr_pend}, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("pend_addr", {62'd0, wr_pend_addr}, {62'd0, e.a});
                        ca   = e.a;
                        cv   = e.v;
                        have = 1'b1;
                    end
                end else begin
                    chk("idle_pend_addr", {62'd0, wr_pend_addr}, 64'd0);
                end
            end
        end
    end

    initial begin
        logic [63:0] s2, s3;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 64'd0;
        wr_be    = 8'h00;
        clr_req  = 1'b0;
        for (int r = 0; r < 4; r++) model[r] = 64'd0;
        #23;
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        cmp_all("rst");
        chk("rst_pend", {63'd0, wr_pend}, 64'd0);
        chk("rst_busy", {63'd0, clr_busy}, 64'd0);
        chk("rst_ready", {63'd0, wr_ready}, 64'd1);

        // Full write to R2 with latency checks.
        cycle(1'b1, 2'd2, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        idle(1);
        chk("t2_pend", {63'd0, wr_pend}, 64'd1);
        chk("t2_pend_addr", {62'd0, wr_pend_addr}, 64'd2);
        idle(1);
        chk("t2_R2", R2, 64'h0123_4567_89AB_CDEF);
        cmp_all("t2");

        // Partial write on R1.
        cycle(1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        cycle(1'b1, 2'd1, 64'd0, 8'h0F, 1'b0);
        idle(2);
        chk("t3_R1", R1, 64'hFFFF_FFFF_0000_0000);

        // Back-to-back to R3, plus a be=0 write that must change nothing.
        cycle(1'b1, 2'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0);
        cycle(1'b1, 2'd3, 64'h1111_1111_1111_1111, 8'h01, 1'b0);
        cycle(1'b1, 2'd3, 64'h5555_5555_5555_5555, 8'h00, 1'b0);
        idle(2);
        chk("t4_R3", R3, 64'hAAAA_AAAA_AAAA_AA11);
        cmp_all("t4");

        // Clear with a same-cycle write and an older staged write to R1.
        cycle(1'b1, 2'd1, 64'h0BAD_F00D_0BAD_F00D, 8'hFF, 1'b0);
        cycle(1'b1, 2'd0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
        idle(5);
        cmp_all("t5");

        // Reset in the middle of a clear.
        cycle(1'b1, 2'd2, {$urandom, $urandom} | 64'd1, 8'hFF, 1'b0);
        cycle(1'b1, 2'd3, {$urandom, $urandom} | 64'd1, 8'hFF, 1'b0);
        idle(2);
        s2 = model[2];
        s3 = model[3];
        cycle(1'b0, 2'd0, 64'd0, 8'h00, 1'b1);
        idle(2);
        chk("t6_R2_before", R2, s2);
        chk("t6_R3_before", R3, s3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_R2", R2, 64'd0);
        chk("t6_R3", R3, 64'd0);
        chk("t6_busy", {63'd0, clr_busy}, 64'd0);
        for (int r = 0; r < 4; r++) model[r] = 64'd0;
        clr_left = 0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_ready", {63'd0, wr_ready}, 64'd1);
        idle(2);
        cmp_all("t6");

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 8'($urandom),
                  (clr_left == 0) && ($urandom_range(0, 24) == 0));
        end
        idle(6);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        cmp_all("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_wregbank4
